// File: rtl/button_conditioner_if.sv
// Button bundle between the raw push-button pins, the conditioner and its consumer.
// The conditioner is the slave: it takes raw buttons in and drives clean outputs.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_in;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_hold;
  logic             conflict;

  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_hold,
    input  conflict
  );

  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_hold,
    output conflict
  );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchroniser, debounce filter, press/hold strobes and a
// multi-press conflict gate feeding digital_lock.
module button_conditioner #(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = 50000,
  parameter int DB_W        = 16,
  parameter int HOLD_CYCLES = 2000000,
  parameter int HOLD_W      = 21
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave bus
);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(HOLD_CYCLES - 1);

  logic [N_BTN-1:0]  r_s1;
  logic [N_BTN-1:0]  r_s2;
  logic [N_BTN-1:0]  r_lvl;
  logic [N_BTN-1:0]  r_press;
  logic [N_BTN-1:0]  r_hold;
  logic              r_conflict;
  logic [DB_W-1:0]   r_cnt [N_BTN];
  logic [HOLD_W-1:0] r_hc  [N_BTN];

  logic [N_BTN-1:0]  w_lvl_nxt;
  logic [N_BTN-1:0]  w_rise;
  logic [N_BTN-1:0]  w_hold_nxt;
  logic              w_multi;
  logic [DB_W-1:0]   w_cnt_nxt [N_BTN];
  logic [HOLD_W-1:0] w_hc_nxt  [N_BTN];

  function automatic logic more_than_one(input logic [N_BTN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (v[i]) n++;
    end
    return (n >= 2);
  endfunction

  always_comb begin
    w_lvl_nxt  = r_lvl;
    w_rise     = '0;
    w_hold_nxt = '0;
    w_cnt_nxt  = r_cnt;
    w_hc_nxt   = r_hc;
    for (int i = 0; i < N_BTN; i++) begin
      // Any sample agreeing with the accepted level restarts the stability count
      if (r_s2[i] == r_lvl[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (r_cnt[i] == DB_LAST) begin
        w_cnt_nxt[i] = '0;
        w_lvl_nxt[i] = r_s2[i];
        w_rise[i]    = r_s2[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + 1'b1;
      end

      // Hold counter saturates, so the strobe fires once per accepted press
      if (!r_lvl[i]) begin
        w_hc_nxt[i] = '0;
      end else if (r_hc[i] < HOLD_MAX) begin
        w_hc_nxt[i]   = r_hc[i] + 1'b1;
        w_hold_nxt[i] = (r_hc[i] == HOLD_PRE);
      end
    end
    w_multi = more_than_one(w_rise);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_lvl      <= '0;
      r_press    <= '0;
      r_hold     <= '0;
      r_conflict <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        r_cnt[i] <= '0;
        r_hc[i]  <= '0;
      end
    end else begin
      r_s1       <= bus.btn_in;
      r_s2       <= r_s1;
      r_lvl      <= w_lvl_nxt;
      r_press    <= w_multi ? '0 : w_rise;
      r_conflict <= w_multi;
      r_hold     <= w_hold_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hc       <= w_hc_nxt;
    end
  end

  assign bus.btn_level = r_lvl;
  assign bus.btn_press = r_press;
  assign bus.btn_hold  = r_hold;
  assign bus.conflict  = r_conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed vector bench for button_conditioner with DB_CYCLES=4, HOLD_CYCLES=10.
// Each vector is one clock: inputs driven at negedge, outputs checked at the next negedge.
module tb_button_conditioner;

  logic clk;
  logic rst;

  button_conditioner_if #(.N_BTN(4)) bus ();

  button_conditioner #(
    .N_BTN(4), .DB_CYCLES(4), .DB_W(3), .HOLD_CYCLES(10), .HOLD_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] in;
    logic [3:0] lvl;
    logic [3:0] press;
    logic [3:0] hold;
    logic       conf;
  } vec_t;

  vec_t tbl[$];
  int   n_vec;
  int   n_bad;
  int   seg_idx;

  // Append n identical one-cycle vectors to the table
  task automatic seg(input string nm, input int n, input logic r, input logic [3:0] in,
                     input logic [3:0] lvl, input logic [3:0] press, input logic [3:0] hold,
                     input logic conf);
    vec_t v;
    v.name = nm; v.rst = r; v.in = in; v.lvl = lvl;
    v.press = press; v.hold = hold; v.conf = conf;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic apply_check(input vec_t v, input int idx);
    rst        = v.rst;
    bus.btn_in = v.in;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (bus.btn_level !== v.lvl || bus.btn_press !== v.press ||
        bus.btn_hold !== v.hold || bus.conflict !== v.conf) begin
      n_bad++;
      $display("FAIL %s[%0d]: got lvl=%b press=%b hold=%b conf=%b, want lvl=%b press=%b hold=%b conf=%b",
               v.name, idx, bus.btn_level, bus.btn_press, bus.btn_hold, bus.conflict,
               v.lvl, v.press, v.hold, v.conf);
    end
  endtask

  // Hand-written sequences: apply n cycles immediately, index restarts per name
  task automatic step(input string nm, input int n, input logic r, input logic [3:0] in,
                      input logic [3:0] lvl, input logic [3:0] press, input logic [3:0] hold,
                      input logic conf);
    vec_t v;
    v.name = nm; v.rst = r; v.in = in; v.lvl = lvl;
    v.press = press; v.hold = hold; v.conf = conf;
    for (int k = 0; k < n; k++) begin
      apply_check(v, seg_idx);
      seg_idx++;
    end
  endtask

  initial begin
    n_vec      = 0;
    n_bad      = 0;
    rst        = 1'b1;
    bus.btn_in = '0;

    //          name    n  rst in      lvl     press   hold    conf
    seg("reset",  2, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    // single press on ch0, released before the hold time
    seg("t1",     5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    seg("t1",     1, 0, 4'h1, 4'h1, 4'h1, 4'h0, 1'b0);
    seg("t1",     2, 0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    seg("t1",     5, 0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
    seg("t1",     5, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    // two 3-cycle glitches on ch1, each one cycle short of acceptance
    seg("t2",     3, 0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
    seg("t2",     4, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    seg("t2",     3, 0, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0);
    seg("t2",     8, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    // ch1 and ch2 resolve together
    seg("t3",     5, 0, 4'h6, 4'h0, 4'h0, 4'h0, 1'b0);
    seg("t3",     1, 0, 4'h6, 4'h6, 4'h0, 4'h0, 1'b1);
    seg("t3",     2, 0, 4'h6, 4'h6, 4'h0, 4'h0, 1'b0);
    seg("t3",     5, 0, 4'h0, 4'h6, 4'h0, 4'h0, 1'b0);
    seg("t3",     5, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) apply_check(tbl[i], i);

    // Long press on ch3, release, re-press: one hold strobe per press
    seg_idx = 0;
    step("t4", 5, 0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t4", 1, 0, 4'h8, 4'h8, 4'h8, 4'h0, 1'b0);
    step("t4", 9, 0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);
    step("t4", 1, 0, 4'h8, 4'h8, 4'h0, 4'h8, 1'b0);
    step("t4", 9, 0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);
    step("t4", 5, 0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0);
    step("t4", 4, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t4", 5, 0, 4'h8, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t4", 1, 0, 4'h8, 4'h8, 4'h8, 4'h0, 1'b0);
    step("t4", 9, 0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);
    step("t4", 1, 0, 4'h8, 4'h8, 4'h0, 4'h8, 1'b0);
    step("t4", 2, 0, 4'h8, 4'h8, 4'h0, 4'h0, 1'b0);
    step("t4", 5, 0, 4'h0, 4'h8, 4'h0, 4'h0, 1'b0);
    step("t4", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Reset mid-debounce, then reset with the level already high
    seg_idx = 0;
    step("t5", 3, 0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t5", 1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t5", 5, 0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t5", 1, 0, 4'h4, 4'h4, 4'h4, 4'h0, 1'b0);
    step("t5", 1, 0, 4'h4, 4'h4, 4'h0, 4'h0, 1'b0);
    step("t5", 1, 1, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t5", 5, 0, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t5", 1, 0, 4'h4, 4'h4, 4'h4, 4'h0, 1'b0);
    step("t5", 5, 0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b0);
    step("t5", 2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // Bouncing release on ch0: level holds until 5 edges after the last bounce
    seg_idx = 0;
    step("t6", 5, 0, 4'h1, 4'h0, 4'h0, 4'h0, 1'b0);
    step("t6", 1, 0, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0);
    step("t6", 1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    step("t6", 1, 0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
    step("t6", 1, 0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0);
    step("t6", 5, 0, 4'h0, 4'h1, 4'h0, 4'h0, 1'b0);
    step("t6", 3, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
